// File: rtl/dsp_simd_addsub_pipe.sv
// Two-stage SIMD signed add/subtract pipeline with per-lane overflow flags and a saturating overflow-beat counter.
// Optional build macro DSP_SIMD_SAT_EN: when defined, overflowing lanes clamp; otherwise they wrap modulo 2^WIDTH.
module dsp_simd_addsub_pipe #(
    parameter int LANES = 2,
    parameter int WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   clken,
    input  logic                   dsp_reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic [LANES-1:0]       sub,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [LANES*WIDTH-1:0] res,
    output logic [LANES-1:0]       ovf,
    output logic [15:0]            ovf_count
);

    // Handshake: a beat moves across an interface on a rising clk edge where its
    // valid and ready are both high (and clken is high); a held valid beat keeps
    // its data stable until taken. S1 refills whenever S2 drains or S1 is empty.
    logic                   v1;
    logic [LANES*WIDTH-1:0] a1;
    logic [LANES*WIDTH-1:0] b1;
    logic [LANES-1:0]       sub1;

    logic                   s2_load;
    logic                   s1_load;
    logic [LANES*WIDTH-1:0] lane_res;
    logic [LANES-1:0]       lane_ovf;
    logic                   out_fire;

    assign s2_load  = clken & (~m_valid | m_ready);
    assign s1_load  = clken & (~v1 | s2_load);
    assign s_ready  = clken & ~dsp_reset & (~v1 | ~m_valid | m_ready);
    assign out_fire = clken & m_valid & m_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [WIDTH:0] opa;
        logic signed [WIDTH:0] opb;
        logic signed [WIDTH:0] exact;

        // One extra bit holds the exact result, so overflow shows as a top-two-bit mismatch.
        assign opa   = {a1[i*WIDTH+WIDTH-1], a1[i*WIDTH +: WIDTH]};
        assign opb   = {b1[i*WIDTH+WIDTH-1], b1[i*WIDTH +: WIDTH]};
        assign exact = sub1[i] ? (opa - opb) : (opa + opb);

        assign lane_ovf[i] = exact[WIDTH] ^ exact[WIDTH-1];

`ifdef DSP_SIMD_SAT_EN
        assign lane_res[i*WIDTH +: WIDTH] = !lane_ovf[i] ? exact[WIDTH-1:0] :
                                            exact[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                                           {1'b0, {(WIDTH-1){1'b1}}};
`else
        assign lane_res[i*WIDTH +: WIDTH] = exact[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            v1        <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            sub1      <= '0;
            m_valid   <= 1'b0;
            res       <= '0;
            ovf       <= '0;
            ovf_count <= '0;
        end else if (dsp_reset) begin
            v1        <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            sub1      <= '0;
            m_valid   <= 1'b0;
            res       <= '0;
            ovf       <= '0;
            ovf_count <= '0;
        end else begin
            if (s1_load) begin
                v1   <= s_valid;
                a1   <= a;
                b1   <= b;
                sub1 <= sub;
            end
            if (s2_load) begin
                m_valid <= v1;
                res     <= lane_res;
                ovf     <= lane_ovf;
            end
            if (out_fire && (|ovf) && (ovf_count != 16'hFFFF)) begin
                ovf_count <= ovf_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dsp_simd_addsub_pipe.sv
// Directed bench for dsp_simd_addsub_pipe (LANES=2, WIDTH=24); expectations follow DSP_SIMD_SAT_EN when defined.
module tb_dsp_simd_addsub_pipe;

    localparam int LANES = 2;
    localparam int WIDTH = 24;
    localparam int DW    = LANES * WIDTH;

`ifdef DSP_SIMD_SAT_EN
    localparam logic [23:0] T2_L0 = 24'h7FFFFF;
    localparam logic [23:0] T3_L1 = 24'h800000;
    localparam logic [23:0] T6_L0 = 24'h7FFFFF;
`else
    localparam logic [23:0] T2_L0 = 24'h800000;
    localparam logic [23:0] T3_L1 = 24'h7FFFFF;
    localparam logic [23:0] T6_L0 = 24'hFFFFFE;
`endif

    logic          clk       = 1'b0;
    logic          aresetn   = 1'b1;
    logic          clken     = 1'b0;
    logic          dsp_reset = 1'b0;
    logic          s_valid   = 1'b0;
    logic          m_ready   = 1'b0;
    logic [DW-1:0] a         = '0;
    logic [DW-1:0] b         = '0;
    logic [1:0]    sub       = '0;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] res;
    logic [1:0]    ovf;
    logic [15:0]   ovf_count;

    int checks = 0;
    int errors = 0;
    logic [49:0] exp_q[$];

    dsp_simd_addsub_pipe #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .clken     (clken),
        .dsp_reset (dsp_reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .res       (res),
        .ovf       (ovf),
        .ovf_count (ovf_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [23:0] a_hi, input logic [23:0] a_lo,
                         input logic [23:0] b_hi, input logic [23:0] b_lo,
                         input logic [1:0] s);
        a       = {a_hi, a_lo};
        b       = {b_hi, b_lo};
        sub     = s;
        s_valid = 1'b1;
    endtask

    // Reference: exact integer lane result, range-checked, then wrapped or clamped.
    function automatic logic [49:0] model(input logic [47:0] ma, input logic [47:0] mb,
                                         input logic [1:0] ms);
        logic [47:0]        r;
        logic [1:0]         o;
        longint             x;
        logic signed [23:0] la;
        logic signed [23:0] lb;
        for (int i = 0; i < 2; i++) begin
            la   = ma[i*24 +: 24];
            lb   = mb[i*24 +: 24];
            x    = ms[i] ? (longint'(la) - longint'(lb)) : (longint'(la) + longint'(lb));
            o[i] = (x > 64'sd8388607) || (x < -64'sd8388608);
`ifdef DSP_SIMD_SAT_EN
            if (x > 64'sd8388607) x = 64'sd8388607;
            else if (x < -64'sd8388608) x = -64'sd8388608;
`endif
            r[i*24 +: 24] = x[23:0];
        end
        return {o, r};
    endfunction

    initial begin
        int          sent;
        int          got;
        int          cyc;
        logic        held;
        logic [DW-1:0] held_res;
        logic [49:0] expv;

        // asynchronous reset before any clock edge
        #2 aresetn = 1'b0;
        #1;
        check("rst_m_valid",   64'(m_valid),   64'd0);
        check("rst_res",       64'(res),       64'd0);
        check("rst_ovf",       64'(ovf),       64'd0);
        check("rst_ovf_count", 64'(ovf_count), 64'd0);
        check("rst_s_ready_clken0", 64'(s_ready), 64'd0);
        clken = 1'b1;
        #1;
        check("rst_s_ready_clken1", 64'(s_ready), 64'd1);
        m_ready = 1'b1;

        // Test 1: plain add, accepted on the first edge after release
        @(negedge clk);
        aresetn = 1'b1;
        drive(24'hFFFFFB, 24'd100, 24'd7, 24'd23, 2'b00);
        #1 check("t1_s_ready", 64'(s_ready), 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
        #1 check("t1_latency_not_early", 64'(m_valid), 64'd0);
        @(negedge clk);
        #1;
        check("t1_m_valid", 64'(m_valid), 64'd1);
        check("t1_res",     64'(res),     64'({24'd2, 24'd123}));
        check("t1_ovf",     64'(ovf),     64'd0);

        // Test 2: positive overflow in lane 0
        drive(24'd10, 24'h7FFFFF, 24'd3, 24'd1, 2'b00);
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        #1;
        check("t2_res", 64'(res), 64'({24'd13, T2_L0}));
        check("t2_ovf", 64'(ovf), 64'd1);
        check("t2_count_before", 64'(ovf_count), 64'd0);
        @(negedge clk);
        #1 check("t2_count_after", 64'(ovf_count), 64'd1);

        // Test 3: negative overflow in lane 1 via subtract
        drive(24'h800000, 24'd0, 24'd1, 24'd0, 2'b10);
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        #1;
        check("t3_res", 64'(res), 64'({T3_L1, 24'd0}));
        check("t3_ovf", 64'(ovf), 64'd2);
        @(negedge clk);
        #1;
        check("t3_count", 64'(ovf_count), 64'd2);
        check("t3_drained", 64'(m_valid), 64'd0);

        // Test 4: 8-beat stream, m_ready pattern 1,0,0,1, random input gaps
        sent = 0;
        got  = 0;
        cyc  = 0;
        held = 1'b0;
        held_res = '0;
        while ((sent < 8 || got < 8) && cyc < 300) begin
            @(negedge clk);
            m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            cyc++;
            if (sent < 8 && $urandom_range(0, 2) != 0)
                drive(24'(-(sent * 37)), 24'(sent * 1000 + 1), 24'd5, 24'(sent * 3), 2'(sent % 4));
            else
                s_valid = 1'b0;
            #1;
            if (held) begin
                check("t4_hold_valid", 64'(m_valid), 64'd1);
                check("t4_hold_res",   64'(res),     64'(held_res));
            end
            held     = m_valid && !m_ready;
            held_res = res;
            if (m_valid && m_ready) begin
                check("t4_out_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    expv = exp_q.pop_front();
                    check("t4_beat", 64'({ovf, res}), 64'(expv));
                end
                got++;
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(model(a, b, sub));
                sent++;
            end
        end
        s_valid = 1'b0;
        check("t4_beats_out", 64'(got), 64'd8);
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        #1 check("t4_count", 64'(ovf_count), 64'd2);

        // Test 5: synchronous clear with two beats in flight
        m_ready = 1'b0;
        drive(24'd1, 24'd1, 24'd1, 24'd1, 2'b00);
        @(negedge clk);
        drive(24'd2, 24'd2, 24'd2, 24'd2, 2'b00);
        @(negedge clk);
        s_valid = 1'b0;
        #1 check("t5_in_flight", 64'(m_valid), 64'd1);
        dsp_reset = 1'b1;
        m_ready   = 1'b1;
        s_valid   = 1'b1;
        #1 check("t5_s_ready_low", 64'(s_ready), 64'd0);
        @(negedge clk);
        dsp_reset = 1'b0;
        s_valid   = 1'b0;
        #1;
        check("t5_m_valid", 64'(m_valid),   64'd0);
        check("t5_count",   64'(ovf_count), 64'd0);
        check("t5_res",     64'(res),       64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 check("t5_no_stale", 64'(m_valid), 64'd0);
        end

        // Test 6: clken low for 3 cycles mid-stream
        m_ready = 1'b1;
        drive(24'd1, 24'h7FFFFF, 24'd1, 24'h7FFFFF, 2'b00);
        @(negedge clk);
        drive(24'd50, 24'd100, 24'd20, 24'd1, 2'b11);
        @(negedge clk);
        clken = 1'b0;
        drive(24'd7, 24'd8, 24'd1, 24'd2, 2'b00);
        #1;
        check("t6_s_ready_off", 64'(s_ready), 64'd0);
        check("t6_x_res", 64'(res), 64'({24'd2, T6_L0}));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("t6_frozen_valid", 64'(m_valid),   64'd1);
            check("t6_frozen_res",   64'(res),       64'({24'd2, T6_L0}));
            check("t6_frozen_ovf",   64'(ovf),       64'd1);
            check("t6_frozen_count", 64'(ovf_count), 64'd0);
            check("t6_frozen_ready", 64'(s_ready),   64'd0);
        end
        clken = 1'b1;
        #1 check("t6_s_ready_on", 64'(s_ready), 64'd1);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        check("t6_y_res",   64'(res),       64'({24'd30, 24'd99}));
        check("t6_y_ovf",   64'(ovf),       64'd0);
        check("t6_count",   64'(ovf_count), 64'd1);
        @(negedge clk);
        #1 check("t6_z_res", 64'(res), 64'({24'd8, 24'd10}));
        @(negedge clk);
        #1 check("t6_drained", 64'(m_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsp_simd_addsub_pipe.md
DSP_SIMD_ADDSUB_PIPE -- requirements
Module: dsp_simd_addsub_pipe

Interface
REQ-001 Parameter LANES, default 2, number of independent signed lanes; legal values 1..4.
REQ-002 Parameter WIDTH, default 24, bits per lane; legal values 8..48.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 aresetn  input  1  reset, asynchronous, active-low.
REQ-005 clken  input  1  global clock enable; when low, no register changes except through aresetn or dsp_reset.
REQ-006 dsp_reset  input  1  synchronous clear; acts regardless of clken.
REQ-007 s_valid  input  1  input beat valid.
REQ-008 s_ready  output  1  input beat accepted when s_valid and s_ready are both high on a clk edge.
REQ-009 a  input  LANES*WIDTH  lane i operand A at bits [i*WIDTH +: WIDTH], signed.
REQ-010 b  input  LANES*WIDTH  lane i operand B at the same packing, signed.
REQ-011 sub  input  LANES  per-lane mode: 0 = A+B, 1 = A-B.
REQ-012 m_valid  output  1  result beat valid.
REQ-013 m_ready  input  1  downstream accepts the result beat.
REQ-014 res  output  LANES*WIDTH  lane results, packed the same as a.
REQ-015 ovf  output  LANES  per-lane signed overflow flag for the beat on res.
REQ-016 ovf_count  output  16  count of accepted output beats with any ovf bit set.

Function
REQ-017 The pipeline has two stages: S1 (registered a, b, sub, plus valid v1) and S2 (registered res, ovf, plus valid m_valid).
REQ-018 Latency from input acceptance to m_valid is exactly 2 enabled cycles when there is no stall.
REQ-019 S2 loads when clken=1 and (m_valid=0 or m_ready=1); it captures S1 contents, and m_valid takes the value of v1.
REQ-020 S1 loads when clken=1 and (v1=0 or S2 loads); v1 takes the value of s_valid and s_ready.
REQ-021 s_ready = clken and (v1=0 or m_valid=0 or m_ready=1), combinational; bubbles in S1 are filled while S2 is stalled.
REQ-022 Full throughput is 1 beat per cycle with m_ready held high; no beat is dropped or duplicated under any m_ready pattern.
REQ-023 While m_valid=1 and m_ready=0, res, ovf and m_valid are held stable.
REQ-024 Lane arithmetic uses WIDTH+1-bit signed intermediates; no carry or borrow propagates between lanes.
REQ-025 ovf[i] = 1 when the exact lane result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-026 ovf_count increments on each S2 output handshake (m_valid and m_ready) with |ovf=1, and saturates at 16'hFFFF.
REQ-027 dsp_reset=1 clears v1, m_valid, res, ovf and ovf_count on the next edge; in-flight beats are discarded, and s_ready is low during that cycle.

Reset
REQ-028 aresetn=0 asynchronously clears v1, m_valid, all data registers, ovf and ovf_count to 0; s_ready then follows REQ-021.
REQ-029 After aresetn is released, the first input beat may be accepted on the first edge with clken=1.

Configuration
REQ-030 Macro DSP_SIMD_SAT_EN: when defined, an overflowing lane result SHALL clamp to 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow).
REQ-031 Without DSP_SIMD_SAT_EN, the lane result SHALL wrap modulo 2^WIDTH; ovf and ovf_count behave identically in both builds.

Verification (LANES=2, WIDTH=24)
REQ-032 Test 1: a={-5, 100}, b={7, 23}, sub=00, m_ready=1 -> two cycles later m_valid=1, res={2, 123}, ovf=00.
REQ-033 Test 2: lane0 a=24'h7FFFFF, b=1, sub=0 -> ovf[0]=1; res lane0 = 24'h7FFFFF with DSP_SIMD_SAT_EN, 24'h800000 without; lane1 unaffected.
REQ-034 Test 3: lane1 a=24'h800000, b=1, sub[1]=1 -> ovf[1]=1; res lane1 = 24'h800000 saturated, 24'h7FFFFF wrapped; ovf_count increments by 1.
REQ-035 Test 4: stream 8 beats with m_ready toggling 1,0,0,1 and random s_valid gaps -> output sequence equals input order with no loss; res stays stable while stalled.
REQ-036 Test 5: assert dsp_reset with 2 beats in flight -> next cycle m_valid=0 and ovf_count=0; no stale beat is emitted afterwards.
REQ-037 Test 6: clken=0 for 3 cycles mid-stream -> s_ready=0 and all outputs frozen; the stream resumes intact.
